// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between two masters.
// Round-robin arbitration happens only in IDLE. Each access is sequenced as
// IDLE -> ACCESS (-> RD_WAIT for reads). Acknowledges are routed by the owner
// recorded at grant time.
module ram_port_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          ram_cs_n,
    output logic          ram_we_n,
    output logic [AW-1:0] ram_addm,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          lastGrant_q, lastGrant_d;
    logic          owner_q, owner_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ramCsN_q, ramCsN_d;
    logic          ramWeN_q, ramWeN_d;
    logic [AW-1:0] ramAddr_q, ramAddr_d;
    logic [DW-1:0] ramDin_q, ramDin_d;
    logic          winner;

    // State and output registers; reset abandons any access and deselects the RAM at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata_q     <= '0;
            ramCsN_q    <= 1'b1;
            ramWeN_q    <= 1'b1;
            ramAddr_q   <= '0;
            ramDin_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata_q     <= rdata_d;
            ramCsN_q    <= ramCsN_d;
            ramWeN_q    <= ramWeN_d;
            ramAddr_q   <= ramAddr_d;
            ramDin_q    <= ramDin_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, strobe the RAM for one cycle, then acknowledge the owner.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata_d     = rdata_q;
        ramCsN_d    = 1'b1;
        ramWeN_d    = 1'b1;
        ramAddr_d   = ramAddr_q;
        ramDin_d    = ramDin_q;
        winner      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // A tie goes to whichever requester was not granted last.
                    winner      = (req0 && req1) ? !lastGrant_q : req1;
                    owner_d     = winner;
                    lastGrant_d = winner;
                    gnt0_d      = !winner;
                    gnt1_d      = winner;
                    ramCsN_d    = 1'b0;
                    ramWeN_d    = winner ? !we1 : !we0;
                    ramAddr_d   = winner ? addr1 : addr0;
                    ramDin_d    = winner ? wdata1 : wdata0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (!ramWeN_q) begin
                    ack0_d  = !owner_q;
                    ack1_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rdata_d = ram_dout;
                ack0_d  = !owner_q;
                ack1_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE);
    assign ram_cs_n = ramCsN_q;
    assign ram_we_n = ramWeN_q;
    assign ram_addm = ramAddr_q;
    assign ram_din  = ramDin_q;

endmodule
